mem_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the picorv32 native memory bus, alongside the on-chip RAM. Decodes its own 16-byte window from `mem_valid`/`mem_addr`, answers with its own `mem_ready`/`mem_rdata`, buffers bytes in a small FIFO and serialises them 8N1 on `uart_tx`. The system-level read mux and `mem_ready` OR-ing sit outside this block.

---
 rtl/mem_uart_tx.sv | 197 +++++++++++++++++++
 tb/tb_mem_uart_tx.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the picorv32 native bus (16-byte window).
// MEM_UART_TX_FIFO_EN selects a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
`timescale 1ns/1ps
module mem_uart_tx #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_C000,
   parameter int unsigned CLK_DIV    = 234,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        uart_tx
);

   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("mem_uart_tx: FIFO_DEPTH must be a power of two in 2..16");
   end

`ifdef MEM_UART_TX_FIFO_EN
   localparam int unsigned DEPTH = FIFO_DEPTH;
`else
   localparam int unsigned DEPTH = 1;
`endif
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   state_e        state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    bit_q, bit_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [15:0]   div_q, div_d;
   logic [15:0]   bdiv_q, bdiv_d;
   logic          tx_q, tx_d;
   logic          ready_q, ready_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [LW-1:0] level_q, level_d;

   logic [7:0]  head;
   logic [15:0] div_wr;
   logic [1:0]  off;
   logic        sel, data_wr, full, busy, push, pop, bit_end;
   logic        unused_bits;

   assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16]};

   assign off     = mem_addr[3:2];
   assign sel     = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]) && !ready_q;
   assign data_wr = sel && (off == 2'd0) && mem_wstrb[0];
   assign full    = (level_q == LW'(DEPTH));
   assign busy    = (state_q != S_IDLE) || (level_q != '0);
   assign pop     = (state_q == S_IDLE) && (level_q != '0);
   // A full FIFO still accepts a push in the cycle the transmitter pops.
   assign push    = data_wr && (!full || pop);

`ifdef MEM_UART_TX_FIFO_EN
   localparam int unsigned PW = $clog2(DEPTH);
   logic [7:0]    fifo_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

   assign wr_ptr_d = wr_ptr_q + PW'(push);
   assign rd_ptr_d = rd_ptr_q + PW'(pop);
   assign head     = fifo_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= mem_wdata[7:0];
   end
`else
   logic [7:0] hold_q;

   assign head = hold_q;

   always_ff @(posedge clk) begin
      if (push) hold_q <= mem_wdata[7:0];
   end
`endif

   always_comb begin
      level_d = level_q;
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (!push && pop) level_d = level_q - LW'(1);

      ready_d = sel && !(data_wr && full && !pop);

      div_wr = {mem_wstrb[1] ? mem_wdata[15:8] : div_q[15:8],
                mem_wstrb[0] ? mem_wdata[7:0]  : div_q[7:0]};
      div_d  = div_q;
      if (ready_d && off == 2'd2 && mem_wstrb != 4'b0000)
         div_d = (div_wr < 16'd2) ? 16'd2 : div_wr;

      rdata_d = '0;
      if (ready_d && mem_wstrb == 4'b0000) begin
         case (off)
            2'd1:    rdata_d = {23'b0, 5'(level_q), 2'b00, full, busy};
            2'd2:    rdata_d = {16'b0, div_q};
            default: rdata_d = '0;
         endcase
      end
   end

   // bdiv holds the divider for the bit in flight; DIV writes land at the next boundary.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      cnt_d   = cnt_q;
      bdiv_d  = bdiv_q;
      bit_end = (cnt_q == bdiv_q - 16'd1);
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               shift_d = head;
               bit_d   = '0;
               cnt_d   = '0;
               bdiv_d  = div_q;
               state_d = S_START;
            end
         end
         S_START: begin
            cnt_d = cnt_q + 16'd1;
            if (bit_end) begin
               cnt_d   = '0;
               bdiv_d  = div_q;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            cnt_d = cnt_q + 16'd1;
            if (bit_end) begin
               cnt_d   = '0;
               bdiv_d  = div_q;
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            cnt_d = cnt_q + 16'd1;
            if (bit_end) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         bit_q    <= '0;
         cnt_q    <= '0;
         div_q    <= 16'(CLK_DIV);
         bdiv_q   <= 16'(CLK_DIV);
         tx_q     <= 1'b1;
         ready_q  <= 1'b0;
         rdata_q  <= '0;
         level_q  <= '0;
`ifdef MEM_UART_TX_FIFO_EN
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         bit_q    <= bit_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         bdiv_q   <= bdiv_d;
         tx_q     <= tx_d;
         ready_q  <= ready_d;
         rdata_q  <= rdata_d;
         level_q  <= level_d;
`ifdef MEM_UART_TX_FIFO_EN
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
`endif
      end
   end

   assign mem_ready = ready_q;
   assign mem_rdata = rdata_q;
   assign uart_tx   = tx_q;

endmodule

// File: tb/tb_mem_uart_tx.sv
// Self-checking bench for mem_uart_tx: bus driver, line capture and a frame-level line model.
`timescale 1ns/1ps
module tb_mem_uart_tx;
`ifdef MEM_UART_TX_FIFO_EN
   localparam int DEPTH = 8;
`else
   localparam int DEPTH = 1;
`endif
   localparam logic [31:0] A_DATA = 32'h0000_C000;
   localparam logic [31:0] A_STAT = 32'h0000_C004;
   localparam logic [31:0] A_DIV  = 32'h0000_C008;
   localparam logic [31:0] A_RSVD = 32'h0000_C00C;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        uart_tx;

   int errors = 0;
   int checks = 0;
   logic cap_q[$];
   logic exp_q[$];

   mem_uart_tx #(
      .BASE_ADDR (32'h0000_C000),
      .CLK_DIV   (234),
      .FIFO_DEPTH(8)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .mem_valid(mem_valid),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready),
      .mem_rdata(mem_rdata),
      .uart_tx  (uart_tx)
   );

   always #5 clk = ~clk;
   always @(negedge clk) cap_q.push_back(uart_tx);

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // One bus transfer; returns at #1 after the acknowledge edge (or after lim cycles).
   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int lim, output logic [31:0] rd, output bit ok, output int waited);
      @(posedge clk); #1;
      mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
      waited = 0; rd = '0; ok = 1'b0;
      do begin
         @(posedge clk); #1;
         waited++;
      end while (!mem_ready && waited < lim);
      ok = mem_ready;
      if (ok) rd = mem_rdata;
      mem_valid = 1'b0; mem_wstrb = '0;
   endtask

   // Expected line for one 8N1 frame at a given bit period, followed by gap idle cycles.
   function automatic void model_frame(input logic [7:0] b, input int div, input int gap);
      for (int k = 0; k < 10; k++) begin
         logic v;
         v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
         repeat (div) exp_q.push_back(v);
      end
      repeat (gap) exp_q.push_back(1'b1);
   endfunction

   function automatic int first_low();
      for (int i = 0; i < cap_q.size(); i++) if (cap_q[i] == 1'b0) return i;
      return -1;
   endfunction

   task automatic test_reset();
      logic [31:0] rd; bit ok; int w;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (uart_tx !== 1'b1 || mem_ready !== 1'b0 || mem_rdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs: tx=%b ready=%b rdata=%h, want 1 0 0", uart_tx, mem_ready, mem_rdata);
      end
      @(posedge clk); #1 resetn = 1'b1;
      bus(A_STAT, 32'd0, 4'b0000, 8, rd, ok, w);
      checks++;
      if (!ok || rd !== 32'h0) begin
         errors++; $display("FAIL reset_status: ok=%0b rdata=%h, want 1 00000000", ok, rd);
      end
      @(posedge clk); #1;
      checks++;
      if (mem_ready !== 1'b0) begin
         errors++; $display("FAIL ready_one_cycle: ready=%b one cycle after ack, want 0", mem_ready);
      end
      bus(A_DIV, 32'd0, 4'b0000, 8, rd, ok, w);
      checks++;
      if (!ok || rd !== 32'd234) begin
         errors++; $display("FAIL reset_div: ok=%0b rdata=%0d, want 234", ok, rd);
      end
   endtask

   task automatic test_single_byte();
      logic [31:0] rd; bit ok, ok2; int w, i0, bad;
      bus(A_DIV, 32'd4, 4'b0011, 8, rd, ok, w);
      repeat (3) @(posedge clk);
      cap_q.delete(); exp_q.delete();
      bus(A_DATA, 32'h55, 4'b0001, 8, rd, ok2, w);
      checks++;
      if (!ok || !ok2 || uart_tx !== 1'b1) begin
         errors++; $display("FAIL tx_idle_at_ack: ok=%0b/%0b tx=%b, want acked and 1", ok, ok2, uart_tx);
      end
      @(posedge clk); #1;
      checks++;
      if (uart_tx !== 1'b0) begin
         errors++; $display("FAIL start_latency: tx=%b two cycles after request, want 0", uart_tx);
      end
      repeat (45) @(posedge clk);
      model_frame(8'h55, 4, 1);
      i0 = first_low();
      bad = 0;
      if (i0 < 0 || cap_q.size() < i0 + exp_q.size()) bad = -1;
      else for (int j = 0; j < exp_q.size(); j++) if (cap_q[i0+j] !== exp_q[j]) bad++;
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL single_frame: %0d samples differ (-1 = frame not found), want 0", bad);
      end
      bus(A_STAT, 32'd0, 4'b0000, 8, rd, ok, w);
      checks++;
      if (!ok || rd[0] !== 1'b0) begin
         errors++; $display("FAIL busy_after_stop: ok=%0b status=%h, want busy 0", ok, rd);
      end
   endtask

   task automatic test_fifo_fill();
      logic [31:0] rd; bit ok; int w, i0, nb, stalls;
      nb = DEPTH + 2;
      bus(A_DIV, 32'd2, 4'b0011, 8, rd, ok, w);
      repeat (30) @(posedge clk);
      cap_q.delete(); exp_q.delete();
      stalls = 0;
      for (int k = 0; k <= DEPTH; k++) begin
         bus(A_DATA, 32'(k), 4'b0001, 8, rd, ok, w);
         if (!ok || w != 1) stalls++;
      end
      checks++;
      if (stalls != 0) begin
         errors++; $display("FAIL fill_no_stall: %0d of first %0d writes stalled, want 0", stalls, DEPTH + 1);
      end
      bus(A_STAT, 32'd0, 4'b0000, 8, rd, ok, w);
      checks++;
      if (!ok || rd[1] !== 1'b1 || rd[8:4] !== 5'(DEPTH)) begin
         errors++; $display("FAIL status_full: status=%h, want full 1 level %0d", rd, DEPTH);
      end
      bus(A_DATA, 32'(DEPTH + 1), 4'b0001, 400, rd, ok, w);
      checks++;
      if (!ok || w <= 1) begin
         errors++; $display("FAIL full_stall: ok=%0b cycles=%0d, want acked after >1 cycles", ok, w);
      end
      checks++;
      if (uart_tx !== 1'b0 || cap_q[$] !== 1'b1) begin
         errors++; $display("FAIL stall_release_at_pop: tx=%b prev=%b, want 0 after 1", uart_tx, cap_q[$]);
      end
      for (int k = 0; k < nb; k++) model_frame(8'(k), 2, 1);
      i0 = first_low();
      for (int c = 0; c < 3000 && (i0 < 0 || cap_q.size() < i0 + nb * 21); c++) begin
         @(posedge clk);
         i0 = first_low();
      end
      for (int f = 0; f < nb; f++) begin
         int bad;
         bad = 0;
         if (i0 < 0 || cap_q.size() < i0 + nb * 21) bad = -1;
         else for (int j = 0; j < 21; j++) if (cap_q[i0+f*21+j] !== exp_q[f*21+j]) bad++;
         checks++;
         if (bad != 0) begin
            errors++; $display("FAIL fifo_frame%0d: %0d samples differ (-1 = missing), want 0", f, bad);
         end
      end
   endtask

   task automatic test_decode();
      logic [31:0] rd; bit ok; int w;
      logic [31:0] addrs [2];
      addrs[0] = 32'h0000_D000;
      addrs[1] = 32'h0000_C010;
      foreach (addrs[n]) begin
         bit okw, okr;
         bus(addrs[n], 32'hA5, 4'b0001, 6, rd, okw, w);
         bus(addrs[n], 32'h0, 4'b0000, 6, rd, okr, w);
         checks++;
         if (okw || okr) begin
            errors++; $display("FAIL decode_%h: ready write=%0b read=%0b, want 0 0", addrs[n], okw, okr);
         end
      end
      bus(A_STAT, 32'd0, 4'b0000, 8, rd, ok, w);
      checks++;
      if (!ok || rd !== 32'h0) begin
         errors++; $display("FAIL decode_no_push: ok=%0b status=%h, want 00000000", ok, rd);
      end
      bus(A_RSVD, 32'hFFFF_FFFF, 4'b1111, 8, rd, ok, w);
      bus(A_RSVD, 32'd0, 4'b0000, 8, rd, ok, w);
      checks++;
      if (!ok || rd !== 32'h0) begin
         errors++; $display("FAIL reserved_read: ok=%0b rdata=%h, want 00000000", ok, rd);
      end
      bus(A_DIV, 32'd0, 4'b0000, 8, rd, ok, w);
      checks++;
      if (!ok || rd !== 32'd2) begin
         errors++; $display("FAIL div_unchanged: rdata=%0d, want 2", rd);
      end
   endtask

   task automatic test_div();
      logic [31:0] rd; bit ok; int w, i0, c, cur, len;
      int runs[$];
      bus(A_DIV, 32'd1, 4'b0011, 8, rd, ok, w);
      bus(A_DIV, 32'd0, 4'b0000, 8, rd, ok, w);
      checks++;
      if (rd !== 32'd2) begin errors++; $display("FAIL div_clamp1: rdata=%0d, want 2", rd); end
      bus(A_DIV, 32'h0000_1234, 4'b0001, 8, rd, ok, w);
      bus(A_DIV, 32'd0, 4'b0000, 8, rd, ok, w);
      checks++;
      if (rd !== 32'h0034) begin errors++; $display("FAIL div_strb0: rdata=%h, want 00000034", rd); end
      bus(A_DIV, 32'h0000_0505, 4'b0010, 8, rd, ok, w);
      bus(A_DIV, 32'd0, 4'b0000, 8, rd, ok, w);
      checks++;
      if (rd !== 32'h0534) begin errors++; $display("FAIL div_strb1: rdata=%h, want 00000534", rd); end
      bus(A_DIV, 32'd0, 4'b0011, 8, rd, ok, w);
      bus(A_DIV, 32'd0, 4'b0000, 8, rd, ok, w);
      checks++;
      if (rd !== 32'd2) begin errors++; $display("FAIL div_clamp0: rdata=%0d, want 2", rd); end

      bus(A_DIV, 32'd6, 4'b0011, 8, rd, ok, w);
      repeat (3) @(posedge clk);
      cap_q.delete();
      bus(A_DATA, 32'h55, 4'b0001, 8, rd, ok, w);
      c = 0;
      while (uart_tx !== 1'b0 && c < 10) begin @(posedge clk); #1; c++; end
      bus(A_DIV, 32'd3, 4'b0011, 8, rd, ok, w);
      repeat (45) @(posedge clk);
      i0 = first_low();
      if (i0 >= 0) begin
         cur = cap_q[i0]; len = 0;
         for (int i = i0; i < cap_q.size(); i++) begin
            if (cap_q[i] == cur) len++;
            else begin runs.push_back(len); cur = cap_q[i]; len = 1; end
         end
      end
      checks++;
      if (runs.size() < 9 || runs[0] != 6) begin
         errors++; $display("FAIL div_current_bit: first run=%0d of %0d runs, want 6", (runs.size() > 0) ? runs[0] : -1, runs.size());
      end
      begin
         int bad;
         bad = 0;
         if (runs.size() < 9) bad = -1;
         else for (int k = 1; k < 9; k++) if (runs[k] != 3) bad++;
         checks++;
         if (bad != 0) begin
            errors++; $display("FAIL div_next_bits: %0d data bits not 3 cycles (-1 = missing), want 0", bad);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] rd; bit ok; int w, nq, lows;
      nq = (DEPTH >= 2) ? 3 : 2;
      bus(A_DIV, 32'd4, 4'b0011, 8, rd, ok, w);
      repeat (3) @(posedge clk);
      for (int k = 0; k < nq; k++) bus(A_DATA, 32'h00, 4'b0001, 8, rd, ok, w);
      repeat (8 - 2 * nq) @(posedge clk);
      #1;
      checks++;
      if (uart_tx !== 1'b0) begin
         errors++; $display("FAIL pre_reset_data: tx=%b during data bit, want 0", uart_tx);
      end
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (uart_tx !== 1'b1) begin
         errors++; $display("FAIL async_reset_tx: tx=%b right after reset, want 1", uart_tx);
      end
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      cap_q.delete();
      bus(A_STAT, 32'd0, 4'b0000, 8, rd, ok, w);
      checks++;
      if (!ok || rd !== 32'h0) begin
         errors++; $display("FAIL reset_flush: ok=%0b status=%h, want 00000000", ok, rd);
      end
      repeat (60) @(posedge clk);
      lows = 0;
      foreach (cap_q[i]) if (cap_q[i] !== 1'b1) lows++;
      checks++;
      if (lows != 0) begin
         errors++; $display("FAIL no_frames_after_reset: %0d low samples, want 0", lows);
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_fifo_fill();
      test_decode();
      test_div();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
